// File: rtl/lane_pkg.sv
// Shared types and default widths for the two-lane barrier scheduler.
package lane_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    OPEN  = 2'd2
  } state_e;

  localparam logic LANE_IN  = 1'b0;
  localparam logic LANE_OUT = 1'b1;

  localparam int PLATE_W = 24;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/lane_barrier_scheduler_rr_arbiter2.sv
// Two-requester round-robin select; the pointer only moves when told to.
module rr_arbiter2
  import lane_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       toggle_i,
  output logic       valid_o,
  output logic       sel_o
);

  logic ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= LANE_IN;
    end else if (toggle_i) begin
      ptr_q <= ~ptr_q;
    end
  end

  assign valid_o = |req_i;
  // The pointer only matters when both lanes contend.
  assign sel_o   = (req_i[0] && req_i[1]) ? ptr_q : req_i[1];

endmodule

// File: rtl/lane_barrier_scheduler.sv
// Shared-barrier sequencer: arbitration, duplicate/capacity filtering,
// open timer and weekly occupancy clear.
module lane_barrier_scheduler
  import lane_pkg::*;
#(
  parameter int PLATE_W     = lane_pkg::PLATE_W,
  parameter int CNT_W       = lane_pkg::CNT_W,
  parameter int CAPACITY    = 15,
  parameter int OPEN_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_in,
  input  logic [PLATE_W-1:0] plate_in,
  input  logic               req_out,
  input  logic [PLATE_W-1:0] plate_out,
  input  logic [2:0]         day,
  output logic               gnt_in,
  output logic               gnt_out,
  output logic               reject,
  output logic               barrier_up,
  output logic [CNT_W-1:0]   count,
  output logic [PLATE_W-1:0] last_plate,
  output logic               full,
  output logic               week_rollover
);

  localparam int TMR_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

  state_e             state_q;
  logic               lane_q;
  logic [PLATE_W-1:0] plate_q;
  logic               accept_q;
  logic               gnt_in_q, gnt_out_q, reject_q, barrier_q, week_q;
  logic [CNT_W-1:0]   count_q;
  logic [PLATE_W-1:0] last_q;
  logic [TMR_W-1:0]   timer_q;
  logic [2:0]         day_q;
  logic               clear_pend_q;

  logic arb_valid, arb_sel, rr_toggle;
  logic accept_d, week_edge;

  // Pointer advances once per finished transaction, accepted or refused.
  assign rr_toggle = ((state_q == CHECK) && !accept_q) ||
                     ((state_q == OPEN) && (timer_q == '0));

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({req_out, req_in}),
    .toggle_i (rr_toggle),
    .valid_o  (arb_valid),
    .sel_o    (arb_sel)
  );

  // Decision is taken while sampling in IDLE; count/last_plate cannot move before CHECK.
  always_comb begin
    accept_d = 1'b0;
    if (arb_sel == LANE_OUT) begin
      accept_d = (count_q != '0);
    end else begin
      accept_d = (plate_in != last_q) && (count_q < CNT_W'(CAPACITY));
    end
  end

  assign week_edge = (day_q == 3'd7) && (day != 3'd7) && (day != 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lane_q       <= LANE_IN;
      plate_q      <= '0;
      accept_q     <= 1'b0;
      gnt_in_q     <= 1'b0;
      gnt_out_q    <= 1'b0;
      reject_q     <= 1'b0;
      barrier_q    <= 1'b0;
      week_q       <= 1'b0;
      count_q      <= '0;
      last_q       <= '0;
      timer_q      <= '0;
      day_q        <= 3'd0;
      clear_pend_q <= 1'b0;
    end else begin
      day_q     <= day;
      gnt_in_q  <= 1'b0;
      gnt_out_q <= 1'b0;
      reject_q  <= 1'b0;
      week_q    <= 1'b0;

      case (state_q)
        IDLE: begin
          if (clear_pend_q) begin
            count_q      <= '0;
            last_q       <= '0;
            week_q       <= 1'b1;
            clear_pend_q <= 1'b0;
          end else if (arb_valid) begin
            lane_q    <= arb_sel;
            plate_q   <= plate_in;
            accept_q  <= accept_d;
            gnt_in_q  <= (arb_sel == LANE_IN);
            gnt_out_q <= (arb_sel == LANE_OUT);
            reject_q  <= !accept_d;
            state_q   <= CHECK;
          end
        end
        CHECK: begin
          if (accept_q) begin
            state_q   <= OPEN;
            barrier_q <= 1'b1;
            timer_q   <= TMR_W'(OPEN_CYCLES - 1);
            if (lane_q == LANE_IN) begin
              count_q <= count_q + CNT_W'(1);
              last_q  <= plate_q;
            end else begin
              count_q <= count_q - CNT_W'(1);
            end
          end else begin
            state_q <= IDLE;
          end
        end
        OPEN: begin
          if (timer_q == '0) begin
            state_q   <= IDLE;
            barrier_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      // A new wrap wins over the clear being consumed on the same edge.
      if (week_edge) begin
        clear_pend_q <= 1'b1;
      end
    end
  end

  assign gnt_in        = gnt_in_q;
  assign gnt_out       = gnt_out_q;
  assign reject        = reject_q;
  assign barrier_up    = barrier_q;
  assign count         = count_q;
  assign last_plate    = last_q;
  assign full          = (count_q == CNT_W'(CAPACITY));
  assign week_rollover = week_q;

endmodule

// File: tb/tb_lane_barrier_scheduler.sv
// Directed and randomized checks of the barrier scheduler against a
// transaction-level occupancy model.
module tb_lane_barrier_scheduler;

  localparam int CAP = 15;
  localparam int OC  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_in, req_out;
  logic [23:0] plate_in, plate_out;
  logic [2:0]  day;
  logic        gnt_in, gnt_out, reject, barrier_up, full, week_rollover;
  logic [3:0]  count;
  logic [23:0] last_plate;

  int total = 0;
  int bad   = 0;

  // transaction-level model
  int          m_count;
  logic [23:0] m_last;
  bit          m_ptr;

  lane_barrier_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .req_in        (req_in),
    .plate_in      (plate_in),
    .req_out       (req_out),
    .plate_out     (plate_out),
    .day           (day),
    .gnt_in        (gnt_in),
    .gnt_out       (gnt_out),
    .reject        (reject),
    .barrier_up    (barrier_up),
    .count         (count),
    .last_plate    (last_plate),
    .full          (full),
    .week_rollover (week_rollover)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_last  = 24'h0;
    m_ptr   = 1'b0;
  endtask

  // One complete transaction from an IDLE cycle back to the next IDLE cycle.
  task automatic do_txn(input bit ri, input bit ro, input logic [23:0] pi, input logic [23:0] po);
    bit lane, acc;
    lane = (ri && ro) ? m_ptr : ro;
    if (lane) acc = (m_count > 0);
    else      acc = (pi != m_last) && (m_count < CAP);

    req_in = ri; plate_in = pi; req_out = ro; plate_out = po;
    tick();
    chk("gnt_in", gnt_in, !lane);
    chk("gnt_out", gnt_out, lane);
    chk("reject", reject, !acc);
    chk("check_barrier", barrier_up, 0);
    req_in = 0; req_out = 0;

    if (acc) begin
      if (lane) m_count--;
      else begin m_count++; m_last = pi; end
      for (int i = 0; i < OC; i++) begin
        tick();
        chk("open_barrier", barrier_up, 1);
        chk("open_count", count, m_count);
      end
      chk("last_plate", last_plate, m_last);
    end
    tick();
    chk("idle_barrier", barrier_up, 0);
    chk("idle_count", count, m_count);
    chk("full", full, m_count == CAP);
    m_ptr = ~m_ptr;
  endtask

  initial begin
    rst = 1'b1; req_in = 0; req_out = 0; plate_in = 0; plate_out = 0; day = 3'd0;
    model_reset();
    tick(); tick();
    chk("rst_gnt_in", gnt_in, 0);
    chk("rst_barrier", barrier_up, 0);
    chk("rst_count", count, 0);
    chk("rst_week", week_rollover, 0);
    rst = 1'b0;

    // first entry, then its duplicate
    do_txn(1, 0, 24'hABC123, 24'h0);
    do_txn(1, 0, 24'hABC123, 24'h0);

    // contention: entry first, exit next
    do_txn(1, 1, 24'h111111, 24'h222222);
    do_txn(1, 1, 24'h111112, 24'h222222);

    // fill to capacity, refuse one more, then let one out
    for (int i = 0; i < 14; i++) do_txn(1, 0, 24'h100000 + 24'(i), 24'h0);
    chk("full_at_cap", full, 1);
    do_txn(1, 0, 24'h000777, 24'h0);
    do_txn(0, 1, 24'h0, 24'h333333);
    chk("count_14", count, 14);
    for (int i = 0; i < 10; i++) do_txn(0, 1, 24'h0, 24'h333333);

    // weekly wrap while the barrier is open
    day = 3'd6;
    tick();
    req_in = 1; plate_in = 24'h555555;
    tick();
    chk("wk_gnt", gnt_in, 1);
    req_in = 0;
    m_count++; m_last = 24'h555555;
    day = 3'd7;
    tick();
    chk("wk_open0", barrier_up, 1);
    day = 3'd1; req_in = 1; plate_in = 24'h666666;
    for (int i = 1; i < OC; i++) begin
      tick();
      chk("wk_open", barrier_up, 1);
      chk("wk_count_held", count, m_count);
      chk("wk_no_roll", week_rollover, 0);
    end
    tick();
    chk("wk_idle_barrier", barrier_up, 0);
    chk("wk_idle_no_gnt", gnt_in, 0);
    chk("wk_idle_count", count, m_count);
    tick();
    chk("wk_roll", week_rollover, 1);
    chk("wk_cleared", count, 0);
    chk("wk_last_cleared", last_plate, 0);
    chk("wk_clear_no_gnt", gnt_in, 0);
    tick();
    chk("wk_next_gnt", gnt_in, 1);
    chk("wk_next_reject", reject, 0);
    chk("wk_roll_once", week_rollover, 0);
    req_in = 0;
    m_count = 1; m_last = 24'h666666; m_ptr = ~m_ptr; m_ptr = ~m_ptr;
    for (int i = 0; i < OC; i++) begin
      tick();
      chk("wk2_open", barrier_up, 1);
      chk("wk2_count", count, m_count);
    end
    tick();
    chk("wk2_idle", barrier_up, 0);

    // reset in the 4th open cycle
    req_in = 1; plate_in = 24'h777777;
    tick();
    chk("rm_gnt", gnt_in, 1);
    req_in = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("rm_open", barrier_up, 1);
    #2 rst = 1'b1;
    #1;
    chk("rm_barrier", barrier_up, 0);
    chk("rm_count", count, 0);
    chk("rm_gnt_in", gnt_in, 0);
    chk("rm_gnt_out", gnt_out, 0);
    chk("rm_reject", reject, 0);
    chk("rm_week", week_rollover, 0);
    chk("rm_last", last_plate, 0);
    tick();
    rst = 1'b0;
    model_reset();
    day = 3'd0;

    // a request withdrawn before it is sampled is ignored
    req_in = 1; plate_in = 24'h888888;
    #2 req_in = 0;
    tick();
    chk("drop_gnt_in", gnt_in, 0);
    chk("drop_gnt_out", gnt_out, 0);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      int kind;
      logic [23:0] p;
      kind = $urandom_range(0, 9);
      p = ($urandom_range(0, 4) == 0) ? m_last : 24'($urandom);
      if (kind <= 5)      do_txn(1, 0, p, 24'($urandom));
      else if (kind <= 7) do_txn(0, 1, 24'($urandom), 24'($urandom));
      else                do_txn(1, 1, p, 24'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
